// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end and its
// fetch-to-decode bus.
package fetch_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int INSN_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  // Byte distance between consecutive instruction words.
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSN_W / 8);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } FetchToDecodeBusPacket;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  // Sequential successor address; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode bus.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                  imem_req_valid;
  logic [ADDR_W-1:0]     imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [INSN_W-1:0]     imem_rsp_data;
  logic                  bus_busy;
  FetchToDecodeBusPacket bus_pkt;
  logic                  bus_recv;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output bus_busy,
    output bus_pkt,
    input  bus_recv
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  bus_busy,
    input  bus_pkt,
    output bus_recv
  );

endinterface

// File: rtl/fetch_bus_register.sv
// Transmit-side register of a stage-to-stage bus: holds one packet and a
// busy flag until the receiver consumes it. Payload type is a parameter so
// later stage buses can reuse it.
module fetch_bus_register #(
  parameter type T = logic [63:0]
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_publish,
  input  logic i_flush,
  input  logic i_recv,
  input  T     i_data,
  output logic o_busy,
  output T     o_data
);

  logic r_busy;
  T     r_data;

  // Flush beats publish beats consume; publish with a same-cycle consume is
  // the back-to-back handover and keeps busy set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_data <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_publish) begin
      r_busy <= 1'b1;
      r_data <= i_data;
    end else if (i_recv) begin
      r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_data = r_data;

  // Receiver must only consume a pending packet.
  a_recv_when_busy : assert property (
    @(posedge clk) disable iff (!reset_n) !(i_recv && !r_busy)
  );

  // A pending packet may only be overwritten when it is consumed the same cycle.
  a_no_overwrite : assert property (
    @(posedge clk) disable iff (!reset_n) !(i_publish && r_busy && !i_recv)
  );

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: walks the PC, keeps one memory request in
// flight, and hands each returned word to decode over the bus register.
// Redirects from execute squash in-flight and published wrong-path work.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset_n,
  fetch_stage_if.master     bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetched_count
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_W-1:0]     r_pc;
  FetchToDecodeBusPacket r_hold;
  logic [31:0]           r_count;

  logic                  w_flush;
  logic                  w_publish;
  logic                  w_capture;
  logic                  w_bus_free;
  logic                  w_busy;
  FetchToDecodeBusPacket w_pkt;
  FetchToDecodeBusPacket w_rsp_pkt;
  FetchToDecodeBusPacket w_pub_pkt;

  assign w_bus_free = !w_busy || bus.bus_recv;
  assign w_rsp_pkt  = '{pc: r_pc, insn: bus.imem_rsp_data};
  // A redirect is ignored only in the one boot cycle after reset.
  assign w_flush    = redirect_valid && (r_state != S_BOOT);

  // Next-state, publish and hold-capture decisions; redirect has top priority.
  always_comb begin
    w_state_next = r_state;
    w_publish    = 1'b0;
    w_capture    = 1'b0;
    w_pub_pkt    = r_hold;
    unique case (r_state)
      S_BOOT: w_state_next = S_REQ;
      S_REQ: begin
        if (w_flush) begin
          // An accepted request for the old path must have its response eaten.
          w_state_next = bus.imem_req_ready ? S_DROP : S_REQ;
        end else if (bus.imem_req_ready) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_flush) begin
          w_state_next = bus.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_rsp_valid) begin
          if (w_bus_free) begin
            w_publish    = 1'b1;
            w_pub_pkt    = w_rsp_pkt;
            w_state_next = S_REQ;
          end else begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_flush) begin
          w_state_next = S_REQ;
        end else if (w_bus_free) begin
          w_publish    = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_DROP: begin
        // Still owed one stale response, redirect or not.
        if (bus.imem_rsp_valid) begin
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_BOOT;
    endcase
  end

  // State, PC, hold buffer and publish counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_flush) begin
        r_pc <= redirect_pc;
      end else if (w_publish) begin
        r_pc <= next_pc(r_pc);
      end
      if (w_flush) begin
        r_hold <= '0;
      end else if (w_capture) begin
        r_hold <= w_rsp_pkt;
      end
      if (w_publish) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  fetch_bus_register #(
    .T (FetchToDecodeBusPacket)
  ) u_bus_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_publish (w_publish),
    .i_flush   (w_flush),
    .i_recv    (bus.bus_recv),
    .i_data    (w_pub_pkt),
    .o_busy    (w_busy),
    .o_data    (w_pkt)
  );

  assign bus.imem_req_valid = (r_state == S_REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.bus_busy       = w_busy;
  assign bus.bus_pkt        = w_pkt;
  assign fetched_count      = r_count;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end and transmitting end of the fetch-to-decode bus. It walks the program counter, issues single-outstanding requests to instruction memory, and publishes each returned word as a FetchToDecodeBusPacket, holding the bus busy flag until decode consumes it. A redirect from execute (branch or exception) squashes in-flight and already-published wrong-path work.

## Interface
- ADDR_W, 32: PC and memory address width.
- INSN_W, 32: instruction word width, a multiple of 8.
- RESET_PC, 0: PC loaded at reset.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  request address, equal to current pc
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  one-cycle response strobe
- imem_rsp_data  in  INSN_W  instruction word
- bus_busy  out  1  packet pending for decode (bus is_busy)
- bus_pkt  out  FetchToDecodeBusPacket  {pc, insn}, stable while bus_busy=1
- bus_recv  in  1  decode consumes bus_pkt this cycle
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch address
- fetched_count  out  32  packets published since reset, wraps

## Operation
- One clock; reset is asynchronous and active-low; every state element clears on reset_n=0.
- Reset values:
  - state=S_BOOT, pc=RESET_PC.
  - bus_busy=0, bus_pkt=0, fetched_count=0, hold buffer=0.
  - imem_req_valid=0.
- imem_req_valid = (state==S_REQ); imem_req_addr = pc.
- "Bus free" = (!bus_busy || bus_recv).
- "Publish X" means all of: bus_pkt<=X, bus_busy<=1, pc<=pc+INSN_W/8 (modulo 2^ADDR_W), fetched_count+=1.
- Transitions:
  - S_BOOT: go to S_REQ unconditionally.
  - S_REQ, no redirect: imem_req_ready=1 goes to S_WAIT; otherwise stay.
  - S_WAIT, no redirect, imem_rsp_valid:
    - bus free: publish {pc, data}, go to S_REQ.
    - bus not free: capture {pc, data} into the hold buffer, go to S_HOLD.
  - S_HOLD, no redirect: when bus free, publish the hold buffer and go to S_REQ.
  - S_DROP: discard the next imem_rsp_valid, then go to S_REQ.
- Redirect (highest priority, any state except S_BOOT):
  - Sets pc<=redirect_pc and bus_busy<=0.
  - Inhibits publish; the hold buffer is discarded.
  - Next state:
    - S_REQ with ready=1: S_DROP.
    - S_REQ with ready=0: S_REQ, re-requesting with the new address.
    - S_WAIT with rsp_valid=1: S_REQ, and that response is dropped.
    - S_WAIT with rsp_valid=0: S_DROP.
    - S_HOLD: S_REQ.
- bus_recv while bus_busy=0 is ignored and is an assertion failure.
- Publishing while bus_busy=1 without same-cycle bus_recv must never occur (assertion).
- A redirect in the same cycle as bus_recv still lets decode see the old bus_pkt that cycle; bus_busy then clears.

## Timing
- Request→response: at least one cycle; any number of wait cycles is allowed.
- Response→bus_busy=1: next edge (registered).
- Steady-state throughput with 1-cycle memory and decode always receiving: one packet per 2 cycles (S_REQ, S_WAIT).
- Back-to-back handover: bus_recv plus publish in the same cycle keeps bus_busy=1 and replaces bus_pkt.
- The first request is visible on the second cycle after reset_n rises.
- Reset asserted mid-transaction: all state clears immediately. A late memory response arriving while in S_BOOT or S_REQ is ignored.

## Structure
- Shared package:
  - FetchToDecodeBusPacket struct {pc[ADDR_W], insn[INSN_W]}.
  - fetch_state_t enum {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_DROP}.
  - RESET_PC default constant.
- Sub-module fetch_bus_register: owns bus_busy and bus_pkt, with inputs publish/flush/recv. It is reused by later stage-to-stage buses.

## Test plan
- Reset then 1-cycle memory, decode always receiving, RESET_PC=0x100 -> packets pc=0x100, 0x104, 0x108, one per 2 cycles; fetched_count=3.
- Decode stalls 5 cycles with bus_busy=1 -> second response enters S_HOLD; bus_pkt is unchanged until bus_recv; the next request issues only after the hold buffer is published; no word is lost.
- Redirect to 0x2000 in S_WAIT with rsp_valid=0 -> stale response discarded in S_DROP; next request addr=0x2000; bus_busy=0 on the cycle after redirect.
- Redirect coinciding with bus_recv and rsp_valid -> decode gets the old packet; the new response is not published; pc=redirect_pc; fetched_count unchanged.
- pc=0xFFFF_FFFC publishes -> next request addr=0x0000_0000.
- reset_n dropped during S_HOLD -> outputs at reset values within the same cycle; after release the fetch restarts at RESET_PC.
